// File: rtl/generador_barrido_pkg.sv
// Shared types and segment patterns for the scan generator and its display driver.
// Patterns are active-low, ordered dp,a,b,c,d,e,f,g from the MSB down.
package generador_barrido_pkg;

    typedef enum logic [1:0] {
        CERO = 2'd0,
        UNO  = 2'd1,
        DOS  = 2'd2
    } estado_t;

    localparam logic [7:0] SEG_CERO = 8'b1000_0001;
    localparam logic [7:0] SEG_UNO  = 8'b1100_1111;
    localparam logic [7:0] SEG_DOS  = 8'b1001_0010;

    function automatic logic [7:0] seg_decode(input estado_t s);
        case (s)
            CERO:    return SEG_CERO;
            UNO:     return SEG_UNO;
            DOS:     return SEG_DOS;
            default: return SEG_CERO;
        endcase
    endfunction

endpackage

// File: rtl/generador_barrido_if.sv
// Button/clear inputs and scan/segment outputs of generador_barrido, bundled as one port.
// master drives the button side and observes the display side; slave is the generator.
interface generador_barrido_if;
    logic       boton;
    logic       borrar;
    logic       tick;
    logic [1:0] conteo;
    logic [7:0] estado;

    modport master (output boton, borrar, input conteo, estado, tick);
    modport slave  (input boton, borrar, output conteo, estado, tick);
endinterface

// File: rtl/antirrebote.sv
// Two-flop synchronizer, counter debouncer and rising-edge detector for a raw push-button.
// avance pulses for one cycle when the accepted level goes from released to pressed.
module antirrebote #(
    parameter int DEB_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic boton,
    output logic avance
);
    localparam int            CW      = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          nivel;
    logic          nivel_q;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronized level disagrees with the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            nivel   <= 1'b0;
            nivel_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= boton;
            sync2   <= sync1;
            nivel_q <= nivel;
            if (sync2 != nivel) begin
                if (cnt == CNT_MAX) begin
                    nivel <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign avance = nivel & ~nivel_q;
endmodule

// File: rtl/generador_barrido.sv
// Digit-scan prescaler/counter plus a button-driven three-state digit shown on digit 3.
// The scan path and the button/FSM path share only the clock and reset.
module generador_barrido
    import generador_barrido_pkg::*;
#(
    parameter int N_DIV   = 50000,
    parameter int DEB_CYC = 500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    generador_barrido_if.slave   bus,
    output estado_t              fsm_dbg
);
    localparam int            PW      = (N_DIV > 1) ? $clog2(N_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(N_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic [1:0]    conteo;
    logic          avance;
    logic [7:0]    seg;
    estado_t       state;
    estado_t       next_state;

    assign tick = (presc == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            conteo <= 2'd0;
        end else begin
            if (tick) begin
                presc  <= '0;
                conteo <= conteo + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    antirrebote #(.DEB_CYC(DEB_CYC)) u_antirrebote (
        .clk    (clk),
        .rst_n  (rst_n),
        .boton  (bus.boton),
        .avance (avance)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CERO;
        else        state <= next_state;
    end

    // Clear wins over a coincident advance.
    always_comb begin
        next_state = state;
        if (bus.borrar) begin
            next_state = CERO;
        end else if (avance) begin
            case (state)
                CERO:    next_state = UNO;
                UNO:     next_state = DOS;
                default: next_state = CERO;
            endcase
        end
    end

    always_comb begin
        seg = seg_decode(state);
    end

    assign bus.tick   = tick;
    assign bus.conteo = conteo;
    assign bus.estado = seg;
    assign fsm_dbg    = state;
endmodule

// File: tb/tb_generador_barrido.sv
// Bench for generador_barrido with a small behavioural model checked every cycle,
// plus directed scenarios pinned to hand-derived literal values.
module tb_generador_barrido;
    localparam int         N_DIV   = 4;
    localparam int         DEB_CYC = 8;
    localparam logic [7:0] P_CERO  = 8'b1000_0001;
    localparam logic [7:0] P_UNO   = 8'b1100_1111;
    localparam logic [7:0] P_DOS   = 8'b1001_0010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] fsm_dbg;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    generador_barrido_if bus ();

    generador_barrido #(.N_DIV(N_DIV), .DEB_CYC(DEB_CYC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .fsm_dbg (fsm_dbg)
    );

    // Model: edges since reset, raw-button history, accepted level with run length, digit 0..2.
    int         m_n = 0;
    logic       m_h1 = 1'b0;
    logic       m_h2 = 1'b0;
    logic       m_acc = 1'b0;
    int         m_run = 0;
    logic       m_pend = 1'b0;
    int         m_st = 0;
    logic [7:0] lut [3];

    initial begin
        lut[0] = P_CERO;
        lut[1] = P_UNO;
        lut[2] = P_DOS;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0; m_h1 <= 1'b0; m_h2 <= 1'b0; m_acc <= 1'b0;
            m_run <= 0; m_pend <= 1'b0; m_st <= 0;
        end else begin
            m_n  <= m_n + 1;
            m_h1 <= bus.boton;
            m_h2 <= m_h1;
            m_pend <= 1'b0;
            if (m_h2 == m_acc) begin
                m_run <= 0;
            end else if (m_run + 1 >= DEB_CYC) begin
                m_acc  <= m_h2;
                m_run  <= 0;
                m_pend <= m_h2;
            end else begin
                m_run <= m_run + 1;
            end
            if (bus.borrar)  m_st <= 0;
            else if (m_pend) m_st <= (m_st + 1) % 3;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        chk("tick", 32'(bus.tick), 32'((m_n % N_DIV) == N_DIV - 1));
        chk("conteo", 32'(bus.conteo), 32'((m_n / N_DIV) % 4));
        chk("estado", 32'(bus.estado), 32'(lut[m_st]));
        chk("fsm_dbg", 32'(fsm_dbg), 32'(m_st));
        chk("estado_legal", 32'(bus.estado == P_CERO || bus.estado == P_UNO || bus.estado == P_DOS), 32'd1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        @(negedge clk);
        bus.boton = 1'b1;
        cyc(20);
        bus.boton = 1'b0;
        cyc(20);
    endtask

    task automatic pin_reset_values(input string tag);
        chk({tag, "_tick"}, 32'(bus.tick), 32'd0);
        chk({tag, "_conteo"}, 32'(bus.conteo), 32'd0);
        chk({tag, "_estado"}, 32'(bus.estado), 32'(P_CERO));
    endtask

    initial begin
        bus.boton  = 1'b0;
        bus.borrar = 1'b0;
        cyc(3);
        pin_reset_values("rst");
        rst_n = 1'b1;

        // Idle scan: tick visible after edge 3, conteo steps every 4 edges.
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #2;
            if (i == 2)  chk("scan_tick_e2", 32'(bus.tick), 32'd0);
            if (i == 3)  chk("scan_tick_e3", 32'(bus.tick), 32'd1);
            if (i == 4)  chk("scan_conteo_e4", 32'(bus.conteo), 32'd1);
            if (i == 12) chk("scan_conteo_e12", 32'(bus.conteo), 32'd3);
            if (i == 16) chk("scan_conteo_e16", 32'(bus.conteo), 32'd0);
            if (i == 40) chk("scan_estado", 32'(bus.estado), 32'(P_CERO));
        end

        // Clean rise: accepted at edge DEB_CYC+2, state moves on the following edge.
        @(negedge clk);
        bus.boton = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #2;
            if (i == DEB_CYC + 2) chk("lat_before", 32'(bus.estado), 32'(P_CERO));
            if (i == DEB_CYC + 3) chk("lat_after", 32'(bus.estado), 32'(P_UNO));
        end
        @(negedge clk);
        bus.boton = 1'b0;
        cyc(20);
        chk("press1_release", 32'(bus.estado), 32'(P_UNO));

        press();
        chk("press2", 32'(bus.estado), 32'(P_DOS));
        press();
        chk("press3_wrap", 32'(bus.estado), 32'(P_CERO));

        // Bounce shorter than the debounce window.
        for (int k = 0; k < 10; k++) begin
            bus.boton = ~bus.boton;
            cyc(3);
        end
        bus.boton = 1'b0;
        cyc(20);
        chk("bounce", 32'(bus.estado), 32'(P_CERO));

        // Clear coinciding with avance while in UNO.
        press();
        chk("pre_clear", 32'(bus.estado), 32'(P_UNO));
        @(negedge clk);
        bus.boton = 1'b1;
        cyc(DEB_CYC + 2);
        bus.borrar = 1'b1;
        cyc(1);
        bus.borrar = 1'b0;
        chk("clear_priority", 32'(bus.estado), 32'(P_CERO));
        cyc(19);
        bus.boton = 1'b0;
        cyc(20);

        // Reset at debounce count 5 with the button held through release.
        @(negedge clk);
        bus.boton = 1'b1;
        cyc(7);
        rst_n = 1'b0;
        cyc(1);
        pin_reset_values("mid_rst");
        cyc(1);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #2;
            if (i == N_DIV - 2)   chk("rel_tick_early", 32'(bus.tick), 32'd0);
            if (i == N_DIV - 1)   chk("rel_tick", 32'(bus.tick), 32'd1);
            if (i == DEB_CYC + 2) chk("rel_before", 32'(bus.estado), 32'(P_CERO));
            if (i == DEB_CYC + 3) chk("rel_after", 32'(bus.estado), 32'(P_UNO));
        end
        @(negedge clk);
        bus.boton = 1'b0;
        cyc(20);

        // Random button activity with occasional clears and resets.
        for (int s = 0; s < 80; s++) begin
            int hold;
            bus.boton = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 20);
            for (int j = 0; j < hold; j++) begin
                bus.borrar = ($urandom_range(0, 30) == 0);
                cyc(1);
            end
            bus.borrar = 1'b0;
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
            end
        end
        bus.boton  = 1'b0;
        bus.borrar = 1'b0;
        cyc(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
